pdp0001_host_sequencer: RTL and testbench
=========================================

Name: pdp0001_host_sequencer

Overview:
Host-side initiator for the pdp0001 4-bit accumulator core's 8-bit command port. It holds a program image (8×2-bit code, 8×4-bit data) written over a simple config port. On start it replays the full command stream into the core: Reset, LoadCode×8, LoadData×8, Reset to the start PC, then Run steps. It monitors the core's {pc, acc} output and stops on a branch-to-self halt or a step limit.

Parameters:
MAX_STEPS, 64, Run-step limit; legal range 1..255.
START_PC, 0, PC loaded by the second Reset before Run (3 bits).

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset_n  input  1  asynchronous, active-low reset
cfg_we  input  1  image write strobe; ignored while busy
cfg_addr  input  4  0-7 = code[addr] (wdata[1:0] used), 8-15 = data[addr-8]
cfg_wdata  input  4  image write data
start  input  1  one-cycle request to run the sequence; ignored while busy
busy  output  1  high from the cycle after start until done is set
done  output  1  set at sequence end; held until the next accepted start
halted  output  1  valid with done: 1 = branch-to-self detected, 0 = step limit reached
step_count  output  8  number of Run commands issued in the current/last sequence
result_pc  output  3  last sampled core pc
result_acc  output  4  last sampled core acc
cpu_io_in  output  8  to core io_in: {arg[3:0], 1'b0, cmd[1:0], strobe}
cpu_io_out  input  8  from core io_out: bit 7 ignored, [6:4] = pc, [3:0] = acc

Behaviour:
- Reset (async, reset_n=0): FSM to IDLE; code/data image, busy, done, halted, step_count, result_pc, result_acc and cpu_io_in all 0.
- Command encoding: Reset=0, LoadCode=1, LoadData=2, Run=3. Bit 3 of cpu_io_in is always 0.
- Every core command takes exactly 3 cycles:
  - SETUP: strobe=0, cmd and arg driven.
  - STROBE: strobe=1, cmd and arg unchanged. The core acts on this rising edge.
  - SETTLE: strobe=0, cmd and arg unchanged. At the end of SETTLE, cpu_io_out is sampled into result_pc and result_acc.
- cmd and arg change only at the SETUP boundary. strobe is registered with no glitches.
- FSM states: IDLE -> RST0 -> LCODE -> LDATA -> RST1 -> RUN -> DONE -> IDLE.
- IDLE: image writes are accepted. When start=1: clear done, halted and step_count; set busy; go to RST0.
- RST0: one Reset command, arg=0.
- LCODE: 8 LoadCode commands, i=0..7, arg={2'b00, code[i]}. The core auto-increments its pc.
- LDATA: 8 LoadData commands, i=0..7, arg=data[i].
- RST1: one Reset command, arg={1'b0, START_PC}. The sampled pc after this command becomes prev_pc.
- RUN: repeated Run commands, arg=0. step_count increments at each STROBE cycle. After SETTLE, the first matching condition applies:
  - sampled pc == prev_pc: halted=1, go to DONE.
  - else step_count == MAX_STEPS: halted=0, go to DONE.
  - otherwise: prev_pc <= sampled pc, issue the next Run.
- DONE: one cycle; busy=0, done=1; return to IDLE with cpu_io_in=0.
- Halt detection is sound: Load, Store and Add always give pc+1 mod 8, so pc is unchanged only for a taken Bz to its own address.
- Total cycles from start to done: 3×(18+step_count)+2.
- Image writes during busy are dropped. The image is not modified by the core's Store operations, since the core keeps its own copy.
- start while busy or in DONE is ignored. start and cfg_we in the same IDLE cycle: the write lands, then the sequence starts using the new value.
- reset_n asserted mid-sequence: everything returns to 0 immediately, including strobe, so no spurious core edge is generated. The core's state is left undefined; the next start reloads it fully.

Test Plan:
- Command stream: image code={0,1,2,1,0,1,2,3}, data={1,4,1,0,9,2,8,7}, start. Check the exact 3-cycle SETUP/STROBE/SETTLE pattern. Check io_in sequence: 0x00/0x01, then LoadCode args 0,1,2,1,0,1,2,3 with cmd=1, then LoadData args 1,4,1,0,9,2,8,7 with cmd=2, then Reset arg 0. Check strobe is high exactly 1 of every 3 cycles.
- Halt: code[0]=Load, data[0]=0, code[1]=Bz, data[1]=1, with a real pdp0001 core attached. Required: done=1, halted=1, step_count=2, result_pc=1, result_acc=0, total cycles 62.
- Step limit: all code=Add, all data=1, MAX_STEPS=64. Required: halted=0, step_count=64, result_pc=0, result_acc=0 (64 mod 16), done after 3×82+2 cycles.
- START_PC=5 with a Bz-to-self (data=5) at address 5 and acc=0 after Reset. Required: halted after 1 step, result_pc=5.
- Ignored inputs: pulse start and cfg_we (addr 8, data 0xF) while busy. Required: no restart and no image change; a rerun shows data[0] at its original value.
- Reset mid-LDATA, e.g. the 4th LoadData SETUP. Required: cpu_io_in=0x00 and busy=0 asynchronously. A fresh start then completes with identical results to an uninterrupted run.

Source files
------------

// File: rtl/pdp0001_host_sequencer.sv
// Host-side initiator for the pdp0001 accumulator core: holds a program image,
// replays it into the core as 3-cycle commands, then single-steps Run until halt or step limit.
module pdp0001_host_sequencer #(
  parameter int MAX_STEPS = 64,
  parameter int START_PC  = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cfg_we,
  input  logic [3:0] cfg_addr,
  input  logic [3:0] cfg_wdata,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       halted,
  output logic [7:0] step_count,
  output logic [2:0] result_pc,
  output logic [3:0] result_acc,
  output logic [7:0] cpu_io_in,
  input  logic [7:0] cpu_io_out,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST0  = 3'd1,
    S_LCODE = 3'd2,
    S_LDATA = 3'd3,
    S_RST1  = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP  = 2'd0,
    PH_STROBE = 2'd1,
    PH_SETTLE = 2'd2
  } phase_t;

  localparam logic [1:0] CMD_RESET = 2'd0;
  localparam logic [1:0] CMD_LCODE = 2'd1;
  localparam logic [1:0] CMD_LDATA = 2'd2;
  localparam logic [1:0] CMD_RUN   = 2'd3;
  localparam logic [7:0] MAX_STEPS_V = 8'(MAX_STEPS);
  localparam logic [2:0] START_PC_V  = 3'(START_PC);

  state_t     state;
  phase_t     phase;
  logic [2:0] idx;
  logic [2:0] prev_pc;
  logic [1:0] cmd_q;
  logic [3:0] arg_q;
  logic       strobe_q;
  logic [1:0] code_mem [8];
  logic [3:0] data_mem [8];

  logic [2:0] io_pc;
  logic [3:0] io_acc;
  logic       unused_io_msb;

  assign io_pc         = cpu_io_out[6:4];
  assign io_acc        = cpu_io_out[3:0];
  assign unused_io_msb = cpu_io_out[7];

  // Every bit of the core command word comes straight from a flop, so strobe never glitches.
  assign cpu_io_in = {arg_q, 1'b0, cmd_q, strobe_q};
  assign state_dbg = state;

  // start is a one-cycle request honoured only in IDLE; image writes likewise land only in IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      phase      <= PH_SETUP;
      idx        <= 3'd0;
      prev_pc    <= 3'd0;
      cmd_q      <= CMD_RESET;
      arg_q      <= 4'd0;
      strobe_q   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      halted     <= 1'b0;
      step_count <= 8'd0;
      result_pc  <= 3'd0;
      result_acc <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        code_mem[i] <= 2'd0;
        data_mem[i] <= 4'd0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_we) begin
            if (cfg_addr[3]) data_mem[cfg_addr[2:0]] <= cfg_wdata;
            else             code_mem[cfg_addr[2:0]] <= cfg_wdata[1:0];
          end
          if (start) begin
            busy       <= 1'b1;
            done       <= 1'b0;
            halted     <= 1'b0;
            step_count <= 8'd0;
            state      <= S_RST0;
            phase      <= PH_SETUP;
            idx        <= 3'd0;
            cmd_q      <= CMD_RESET;
            arg_q      <= 4'd0;
            strobe_q   <= 1'b0;
          end
        end

        S_RST0, S_LCODE, S_LDATA, S_RST1, S_RUN: begin
          case (phase)
            PH_SETUP: begin
              strobe_q <= 1'b1;
              phase    <= PH_STROBE;
            end
            PH_STROBE: begin
              strobe_q <= 1'b0;
              phase    <= PH_SETTLE;
              if (state == S_RUN) step_count <= step_count + 8'd1;
            end
            PH_SETTLE: begin
              phase      <= PH_SETUP;
              result_pc  <= io_pc;
              result_acc <= io_acc;
              case (state)
                S_RST0: begin
                  state <= S_LCODE;
                  idx   <= 3'd0;
                  cmd_q <= CMD_LCODE;
                  arg_q <= {2'b00, code_mem[0]};
                end
                S_LCODE: begin
                  if (idx == 3'd7) begin
                    state <= S_LDATA;
                    idx   <= 3'd0;
                    cmd_q <= CMD_LDATA;
                    arg_q <= data_mem[0];
                  end else begin
                    idx   <= idx + 3'd1;
                    arg_q <= {2'b00, code_mem[idx + 3'd1]};
                  end
                end
                S_LDATA: begin
                  if (idx == 3'd7) begin
                    state <= S_RST1;
                    idx   <= 3'd0;
                    cmd_q <= CMD_RESET;
                    arg_q <= {1'b0, START_PC_V};
                  end else begin
                    idx   <= idx + 3'd1;
                    arg_q <= data_mem[idx + 3'd1];
                  end
                end
                S_RST1: begin
                  state   <= S_RUN;
                  prev_pc <= io_pc;
                  cmd_q   <= CMD_RUN;
                  arg_q   <= 4'd0;
                end
                S_RUN: begin
                  // Only a taken Bz to its own address leaves pc unchanged.
                  if (io_pc == prev_pc || step_count == MAX_STEPS_V) begin
                    halted <= (io_pc == prev_pc);
                    state  <= S_DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    cmd_q  <= CMD_RESET;
                    arg_q  <= 4'd0;
                  end else begin
                    prev_pc <= io_pc;
                  end
                end
                default: state <= S_IDLE;
              endcase
            end
            default: begin
              phase    <= PH_SETUP;
              strobe_q <= 1'b0;
            end
          endcase
        end

        S_DONE: state <= S_IDLE;

        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          cmd_q    <= CMD_RESET;
          arg_q    <= 4'd0;
          strobe_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdp0001_host_sequencer.sv
// Bench for pdp0001_host_sequencer: two instances (different START_PC/MAX_STEPS), each driving a
// behavioural pdp0001 core, checked cycle by cycle against a program-level reference model.
module tb_pdp0001_host_sequencer;

  localparam int MS0 = 64;
  localparam int SP0 = 0;
  localparam int MS1 = 3;
  localparam int SP1 = 5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic       cfg_we_s [2];
  logic       start_s  [2];
  logic [3:0] cfg_addr;
  logic [3:0] cfg_wdata;
  logic       busy_w   [2];
  logic       done_w   [2];
  logic       halted_w [2];
  logic [7:0] steps_w  [2];
  logic [2:0] pc_w     [2];
  logic [3:0] acc_w    [2];
  logic [7:0] io_in_w  [2];
  logic [7:0] io_out_w [2];
  logic [2:0] st_w     [2];

  pdp0001_host_sequencer #(.MAX_STEPS(MS0), .START_PC(SP0)) u_seq0 (
    .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we_s[0]), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start_s[0]), .busy(busy_w[0]), .done(done_w[0]),
    .halted(halted_w[0]), .step_count(steps_w[0]), .result_pc(pc_w[0]), .result_acc(acc_w[0]),
    .cpu_io_in(io_in_w[0]), .cpu_io_out(io_out_w[0]), .state_dbg(st_w[0])
  );

  pdp0001_host_sequencer #(.MAX_STEPS(MS1), .START_PC(SP1)) u_seq1 (
    .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we_s[1]), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start_s[1]), .busy(busy_w[1]), .done(done_w[1]),
    .halted(halted_w[1]), .step_count(steps_w[1]), .result_pc(pc_w[1]), .result_acc(acc_w[1]),
    .cpu_io_in(io_in_w[1]), .cpu_io_out(io_out_w[1]), .state_dbg(st_w[1])
  );

  // ---------------- behavioural pdp0001 cores ----------------
  // Instructions: 0 Load imm, 1 Store acc to data[imm], 2 Add imm, 3 Bz imm.
  logic [1:0] core_code [2][8];
  logic [3:0] core_data [2][8];
  logic [2:0] core_pc   [2];
  logic [3:0] core_acc  [2];
  logic       core_b7   [2];

  assign io_out_w[0] = {core_b7[0], core_pc[0], core_acc[0]};
  assign io_out_w[1] = {core_b7[1], core_pc[1], core_acc[1]};

  initial begin
    for (int k = 0; k < 2; k++) begin
      core_pc[k] = 3'd0; core_acc[k] = 4'd0; core_b7[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin core_code[k][i] = 2'd0; core_data[k][i] = 4'd0; end
    end
  end

  task automatic core_exec(input int k, input logic [7:0] io);
    logic [3:0] arg, opd;
    arg = io[7:4];
    case (io[2:1])
      2'd0: begin core_pc[k] = arg[2:0]; core_acc[k] = 4'd0; end
      2'd1: begin core_code[k][core_pc[k]] = arg[1:0]; core_pc[k] = core_pc[k] + 3'd1; end
      2'd2: begin core_data[k][core_pc[k]] = arg; core_pc[k] = core_pc[k] + 3'd1; end
      default: begin
        opd = core_data[k][core_pc[k]];
        case (core_code[k][core_pc[k]])
          2'd0: begin core_acc[k] = opd; core_pc[k] = core_pc[k] + 3'd1; end
          2'd1: begin core_data[k][opd[2:0]] = core_acc[k]; core_pc[k] = core_pc[k] + 3'd1; end
          2'd2: begin core_acc[k] = core_acc[k] + opd; core_pc[k] = core_pc[k] + 3'd1; end
          default: core_pc[k] = (core_acc[k] == 4'd0) ? opd[2:0] : core_pc[k] + 3'd1;
        endcase
      end
    endcase
    core_b7[k] = 1'($urandom);
  endtask

  always @(posedge clock) begin
    if (io_in_w[0][0] === 1'b1) core_exec(0, io_in_w[0]);
    if (io_in_w[1][0] === 1'b1) core_exec(1, io_in_w[1]);
  end

  // ---------------- image model / reference ----------------
  logic [1:0] img_code [2][8];
  logic [3:0] img_data [2][8];
  logic [7:0] exp_q [$];

  int checks   = 0;
  int failures = 0;

  bit         obs_halted;
  int         obs_steps;
  int         obs_total;
  logic [2:0] obs_pc;
  logic [3:0] obs_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin img_code[k][i] = 2'd0; img_data[k][i] = 4'd0; end
  endtask

  function automatic void model_write(input int k, input logic [3:0] a, input logic [3:0] v);
    if (a[3]) img_data[k][a[2:0]] = v;
    else      img_code[k][a[2:0]] = v[1:0];
  endfunction

  // Program-level execution: count Run steps until pc repeats or the limit is hit.
  function automatic void ref_run(input int k, input int spc, input int maxs, output bit h,
                                  output int n, output logic [2:0] pc_o, output logic [3:0] acc_o);
    logic [3:0] d [8];
    logic [2:0] pc, npc;
    logic [3:0] acc, opd;
    for (int i = 0; i < 8; i++) d[i] = img_data[k][i];
    pc = 3'(spc); acc = 4'd0; n = 0; h = 1'b0;
    while (1) begin
      opd = d[pc];
      npc = pc + 3'd1;
      case (img_code[k][pc])
        2'd0: acc = opd;
        2'd1: d[opd[2:0]] = acc;
        2'd2: acc = acc + opd;
        default: if (acc == 4'd0) npc = opd[2:0];
      endcase
      n++;
      if (npc == pc) begin h = 1'b1; break; end
      pc = npc;
      if (n == maxs) break;
    end
    pc_o = npc; acc_o = acc;
  endfunction

  function automatic void push_cmd(input logic [1:0] c, input logic [3:0] a);
    exp_q.push_back({a, 1'b0, c, 1'b0});
    exp_q.push_back({a, 1'b0, c, 1'b1});
    exp_q.push_back({a, 1'b0, c, 1'b0});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_cfg(input int k, input logic [3:0] a, input logic [3:0] v);
    @(negedge clock);
    cfg_we_s[k] = 1'b1; cfg_addr = a; cfg_wdata = v;
    model_write(k, a, v);
    @(negedge clock);
    cfg_we_s[k] = 1'b0;
  endtask

  task automatic load_img(input int k, input logic [15:0] cp, input logic [31:0] dp);
    for (int i = 0; i < 8; i++) write_cfg(k, 4'(i), {2'b00, cp[2*i +: 2]});
    for (int i = 0; i < 8; i++) write_cfg(k, 4'(8 + i), dp[4*i +: 4]);
  endtask

  // One sequence on instance k. poke: pulse start + cfg write mid-run. abort: reset in 4th LoadData SETUP.
  task automatic run_seq(input int k, input bit poke, input bit abort, input int sw_addr,
                         input logic [3:0] sw_val);
    bit         r_h;
    int         r_n, cyc, spc, maxs, budget;
    logic [2:0] r_pc;
    logic [3:0] r_acc;
    logic [7:0] e;
    spc  = (k == 0) ? SP0 : SP1;
    maxs = (k == 0) ? MS0 : MS1;
    if (sw_addr >= 0) model_write(k, 4'(sw_addr), sw_val);
    ref_run(k, spc, maxs, r_h, r_n, r_pc, r_acc);
    exp_q.delete();
    push_cmd(2'd0, 4'd0);
    for (int i = 0; i < 8; i++) push_cmd(2'd1, {2'b00, img_code[k][i]});
    for (int i = 0; i < 8; i++) push_cmd(2'd2, img_data[k][i]);
    push_cmd(2'd0, 4'(spc));
    for (int i = 0; i < r_n; i++) push_cmd(2'd3, 4'd0);
    budget = 3 * (18 + 255) + 8;

    @(negedge clock);
    start_s[k] = 1'b1;
    if (sw_addr >= 0) begin cfg_we_s[k] = 1'b1; cfg_addr = 4'(sw_addr); cfg_wdata = sw_val; end
    @(negedge clock);
    start_s[k] = 1'b0; cfg_we_s[k] = 1'b0;
    cyc = 1;
    while (done_w[k] !== 1'b1 && cyc < budget) begin
      e = (cyc - 1 < exp_q.size()) ? exp_q[cyc-1] : 8'hFF;
      check("io_in", io_in_w[k], e);
      check("busy", busy_w[k], 1);
      if (abort && cyc == 37) begin
        reset_n = 1'b0;
        #1;
        check("rst_io_in", io_in_w[k], 0);
        check("rst_busy", busy_w[k], 0);
        check("rst_steps", steps_w[k], 0);
        @(negedge clock);
        reset_n = 1'b1;
        clear_img();
        return;
      end
      if (poke && cyc == 10) begin
        start_s[k] = 1'b1; cfg_we_s[k] = 1'b1; cfg_addr = 4'd8; cfg_wdata = 4'hF;
      end
      if (poke && cyc == 11) begin start_s[k] = 1'b0; cfg_we_s[k] = 1'b0; end
      @(negedge clock);
      cyc++;
    end
    check("done_reached", done_w[k], 1);
    check("total_cycles", cyc + 1, 3 * (18 + r_n) + 2);
    check("halted", halted_w[k], r_h);
    check("step_count", steps_w[k], r_n);
    check("result_pc", pc_w[k], r_pc);
    check("result_acc", acc_w[k], r_acc);
    check("done_busy", busy_w[k], 0);
    check("done_io_in", io_in_w[k], 0);
    obs_halted = halted_w[k]; obs_steps = steps_w[k]; obs_pc = pc_w[k];
    obs_acc = acc_w[k]; obs_total = cyc + 1;
    @(negedge clock);
    check("done_held", done_w[k], 1);
    check("idle_io_in", io_in_w[k], 0);
    check("idle_busy", busy_w[k], 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit         ref_h;
    int         ref_s, kk;
    logic [2:0] ref_p;
    logic [3:0] ref_a;
    logic [15:0] cp;
    logic [31:0] dp;

    reset_n = 1'b0;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    cfg_we_s[0] = 1'b0; cfg_we_s[1] = 1'b0;
    cfg_addr = 4'd0; cfg_wdata = 4'd0;
    clear_img();
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", busy_w[k], 0);
      check("rst_done", done_w[k], 0);
      check("rst_halted", halted_w[k], 0);
      check("rst_steps", steps_w[k], 0);
      check("rst_pc", pc_w[k], 0);
      check("rst_acc", acc_w[k], 0);
      check("rst_io_in", io_in_w[k], 0);
      check("rst_state", st_w[k], 0);
    end
    reset_n = 1'b1;
    @(negedge clock);

    // Command stream image
    load_img(0, 16'hE464, 32'h7829_0141);
    run_seq(0, 1'b0, 1'b0, -1, 4'd0);

    // Load 0 then Bz-to-self at address 1
    load_img(0, 16'h000C, 32'h0000_0010);
    run_seq(0, 1'b0, 1'b0, -1, 4'd0);
    check("halt_halted", obs_halted, 1);
    check("halt_steps", obs_steps, 2);
    check("halt_pc", obs_pc, 1);
    check("halt_acc", obs_acc, 0);
    check("halt_cycles", obs_total, 62);

    // All Add 1: runs into the 64-step limit
    load_img(0, 16'hAAAA, 32'h1111_1111);
    run_seq(0, 1'b0, 1'b0, -1, 4'd0);
    check("limit_halted", obs_halted, 0);
    check("limit_steps", obs_steps, 64);
    check("limit_pc", obs_pc, 0);
    check("limit_acc", obs_acc, 0);
    check("limit_cycles", obs_total, 3 * 82 + 2);

    // START_PC=5 with Bz-to-self at 5
    load_img(1, 16'h0C00, 32'h0050_0000);
    run_seq(1, 1'b0, 1'b0, -1, 4'd0);
    check("spc_halted", obs_halted, 1);
    check("spc_steps", obs_steps, 1);
    check("spc_pc", obs_pc, 5);

    // start and image write while busy are dropped
    load_img(0, 16'hE464, 32'h7829_0141);
    run_seq(0, 1'b1, 1'b0, -1, 4'd0);
    run_seq(0, 1'b0, 1'b0, -1, 4'd0);
    ref_h = obs_halted; ref_s = obs_steps; ref_p = obs_pc; ref_a = obs_acc;

    // Reset in the middle of LDATA, then a clean rerun
    run_seq(0, 1'b0, 1'b1, -1, 4'd0);
    check("post_rst_done", done_w[0], 0);
    load_img(0, 16'hE464, 32'h7829_0141);
    run_seq(0, 1'b0, 1'b0, -1, 4'd0);
    check("rerun_halted", obs_halted, ref_h);
    check("rerun_steps", obs_steps, ref_s);
    check("rerun_pc", obs_pc, ref_p);
    check("rerun_acc", obs_acc, ref_a);

    // Random images, sometimes with a write landing in the start cycle
    for (int t = 0; t < 8; t++) begin
      kk = t % 2;
      cp = 16'($urandom);
      dp = $urandom;
      load_img(kk, cp, dp);
      if ($urandom_range(0, 1) == 1)
        run_seq(kk, 1'b0, 1'b0, int'($urandom_range(0, 15)), 4'($urandom));
      else
        run_seq(kk, 1'b0, 1'b0, -1, 4'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
